mips_exec_core: RTL and testbench
=================================

MIPS_EXEC_CORE -- requirements
Module: mips_exec_core

Interface
REQ-001 Parameter: DM_WORDS, 1024, data-memory depth in 32-bit words (4 KiB).
REQ-002 Port: clk  in  1  single clock; memory writes on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: ins  in  32  current instruction (op=ins[31:26], rs, rt, rd, shamt=ins[10:6], funct=ins[5:0], imm16=ins[15:0]).
REQ-005 Port: busA  in  32  register-file rs value.
REQ-006 Port: busB  in  32  register-file rt value; also store data.
REQ-007 Port: alu_out  out  32  ALU result (also memory byte address).
REQ-008 Port: zero  out  1  high when alu_out == 0.
REQ-009 Port: wb_data  out  32  write-back data: memory load data when memToReg else alu_out.
REQ-010 Port: branch  out  2  00 none, 01 beq, 10 bne, 11 REGIMM (bgez/bltz, resolved by next-PC logic).
REQ-011 Port: jump, regDst, regL, regWr, memWr, extOp, memToReg  out  1 each  decoded controls (regDst=1 selects rd; regL=1 writes PC+4 into $31/rd; extOp=1 sign-extends imm16).

Function
REQ-012 Control, ALU and load path SHALL be purely combinational from ins/busA/busB/memory contents; zero-cycle latency.
REQ-013 Decoded set: R-type addu, subu, add, sub, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr, jalr; addiu, addi, andi, ori, xori, lui, slti, sltiu, lw, lb, lbu, lh, lhu, sw, sb, sh, beq, bne, bgez/bltz (op 000001), j, jal.
REQ-014 Unlisted opcode/funct SHALL drive all write/branch/jump controls 0 (nop).
REQ-015 aluOp codes (5 bits): 0 ADDU, 1 SUBU, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLT (signed), 9 SLTU, 10 SLL, 11 SRL, 12 SRA (shift busB by shamt), 13 SLLV, 14 SRLV, 15 SRAV (shift busB by busA[4:0]), 16 LUI (imm << 16); other codes give 0.
REQ-016 ALU operand B SHALL be the extended immediate when aluSrc=1, else busB; andi/ori/xori zero-extend, all other immediates sign-extend.
REQ-017 add/sub/addi SHALL wrap modulo 2^32; no overflow trap.
REQ-018 beq/bne SHALL use SUBU so zero reports equality; jal/jalr SHALL set regL=1 and regWr=1 (jal destination $31, jalr rd); jr/jalr set jump=1.
REQ-019 Memory byte address = alu_out[11:0]; little-endian lanes; word access ignores addr[1:0], halfword ignores addr[0].
REQ-020 Loads: lw full word; lb/lh sign-extend; lbu/lhu zero-extend.
REQ-021 Stores (memWr=1, rst high): sw writes word, sh writes 16-bit lane, sb writes 8-bit lane at the rising clk edge; other bytes unchanged.
REQ-022 Read-during-write same address SHALL return old data until after the edge.

Reset
REQ-023 While rst=0 all memory words SHALL read 0 (cleared asynchronously) and stores SHALL be suppressed.
REQ-024 Combinational outputs depend only on inputs and memory; no other state exists.

Structure
REQ-025 aluOp encodings, opcode and funct constants SHALL live in shared package mips_pkg.
REQ-026 Internal sub-modules: mips_ctrl_dec (decoder), mips_alu_unit, mips_dmem; top instantiates them plus aluSrc/memToReg muxes.

Verification
REQ-027 ins=addu $3,$1,$2, busA=7, busB=0xFFFFFFF9 -> alu_out=0, zero=1, regDst=1, regWr=1.
REQ-028 ins=ori rt,rs,0x8000, busA=0x00010000 -> alu_out=0x00018000, extOp=0; addiu imm 0x8000, busA=0 -> 0xFFFF8000.
REQ-029 sw busB=0x11223344 to addr 0x10, then lb addr 0x13 -> wb_data=0x00000011; sb 0x80 to 0x11 then lb 0x11 -> 0xFFFFFF80, lbu -> 0x00000080.
REQ-030 ins=0x07210010 (bgez) -> branch=11, regWr=0, memWr=0; beq with busA=busB=5 -> branch=01, zero=1.
REQ-031 sra shamt=4, busB=0x80000000 -> 0xF8000000; slt busA=-1, busB=1 -> 1; sltu same -> 0.
REQ-032 Store then assert rst low mid-run -> all loads return 0; store attempted during rst low -> no effect after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, ALU operation codes and decoded control bundle
// for the MIPS execute/memory slice.
package mips_pkg;

    localparam logic [5:0] OpRtype  = 6'h00;
    localparam logic [5:0] OpRegimm = 6'h01;
    localparam logic [5:0] OpJ      = 6'h02;
    localparam logic [5:0] OpJal    = 6'h03;
    localparam logic [5:0] OpBeq    = 6'h04;
    localparam logic [5:0] OpBne    = 6'h05;
    localparam logic [5:0] OpAddi   = 6'h08;
    localparam logic [5:0] OpAddiu  = 6'h09;
    localparam logic [5:0] OpSlti   = 6'h0a;
    localparam logic [5:0] OpSltiu  = 6'h0b;
    localparam logic [5:0] OpAndi   = 6'h0c;
    localparam logic [5:0] OpOri    = 6'h0d;
    localparam logic [5:0] OpXori   = 6'h0e;
    localparam logic [5:0] OpLui    = 6'h0f;
    localparam logic [5:0] OpLb     = 6'h20;
    localparam logic [5:0] OpLh     = 6'h21;
    localparam logic [5:0] OpLw     = 6'h23;
    localparam logic [5:0] OpLbu    = 6'h24;
    localparam logic [5:0] OpLhu    = 6'h25;
    localparam logic [5:0] OpSb     = 6'h28;
    localparam logic [5:0] OpSh     = 6'h29;
    localparam logic [5:0] OpSw     = 6'h2b;

    localparam logic [5:0] FnSll  = 6'h00;
    localparam logic [5:0] FnSrl  = 6'h02;
    localparam logic [5:0] FnSra  = 6'h03;
    localparam logic [5:0] FnSllv = 6'h04;
    localparam logic [5:0] FnSrlv = 6'h06;
    localparam logic [5:0] FnSrav = 6'h07;
    localparam logic [5:0] FnJr   = 6'h08;
    localparam logic [5:0] FnJalr = 6'h09;
    localparam logic [5:0] FnAdd  = 6'h20;
    localparam logic [5:0] FnAddu = 6'h21;
    localparam logic [5:0] FnSub  = 6'h22;
    localparam logic [5:0] FnSubu = 6'h23;
    localparam logic [5:0] FnAnd  = 6'h24;
    localparam logic [5:0] FnOr   = 6'h25;
    localparam logic [5:0] FnXor  = 6'h26;
    localparam logic [5:0] FnNor  = 6'h27;
    localparam logic [5:0] FnSlt  = 6'h2a;
    localparam logic [5:0] FnSltu = 6'h2b;

    typedef enum logic [4:0] {
        AluAddu = 5'd0,
        AluSubu = 5'd1,
        AluAdd  = 5'd2,
        AluSub  = 5'd3,
        AluAnd  = 5'd4,
        AluOr   = 5'd5,
        AluXor  = 5'd6,
        AluNor  = 5'd7,
        AluSlt  = 5'd8,
        AluSltu = 5'd9,
        AluSll  = 5'd10,
        AluSrl  = 5'd11,
        AluSra  = 5'd12,
        AluSllv = 5'd13,
        AluSrlv = 5'd14,
        AluSrav = 5'd15,
        AluLui  = 5'd16
    } alu_op_e;

    typedef enum logic [1:0] {
        MemByte = 2'd0,
        MemHalf = 2'd1,
        MemWord = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        BrNone   = 2'b00,
        BrBeq    = 2'b01,
        BrBne    = 2'b10,
        BrRegimm = 2'b11
    } branch_e;

    typedef struct packed {
        branch_e   branch;
        logic      jump;
        logic      reg_dst;
        logic      reg_l;
        logic      reg_wr;
        logic      mem_wr;
        logic      ext_op;
        logic      mem_to_reg;
        logic      alu_src;
        alu_op_e   alu_op;
        mem_size_e mem_size;
        logic      load_unsigned;
    } ctrl_t;

    localparam ctrl_t CtrlNop = '{
        branch:        BrNone,
        jump:          1'b0,
        reg_dst:       1'b0,
        reg_l:         1'b0,
        reg_wr:        1'b0,
        mem_wr:        1'b0,
        ext_op:        1'b0,
        mem_to_reg:    1'b0,
        alu_src:       1'b0,
        alu_op:        AluAddu,
        mem_size:      MemWord,
        load_unsigned: 1'b0
    };

endpackage

// File: rtl/mips_alu_unit.sv
// Combinational 32-bit ALU; arithmetic wraps, unknown op codes yield zero.
module mips_alu_unit
    import mips_pkg::*;
(
    input  alu_op_e     alu_op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  shamt_i,
    output logic [31:0] result_o,
    output logic        zero_o
);

    always_comb begin
        case (alu_op_i)
            AluAddu, AluAdd: result_o = a_i + b_i;
            AluSubu, AluSub: result_o = a_i - b_i;
            AluAnd:  result_o = a_i & b_i;
            AluOr:   result_o = a_i | b_i;
            AluXor:  result_o = a_i ^ b_i;
            AluNor:  result_o = ~(a_i | b_i);
            AluSlt:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            AluSltu: result_o = {31'd0, a_i < b_i};
            AluSll:  result_o = b_i << shamt_i;
            AluSrl:  result_o = b_i >> shamt_i;
            AluSra:  result_o = $unsigned($signed(b_i) >>> shamt_i);
            AluSllv: result_o = b_i << a_i[4:0];
            AluSrlv: result_o = b_i >> a_i[4:0];
            AluSrav: result_o = $unsigned($signed(b_i) >>> a_i[4:0]);
            AluLui:  result_o = {b_i[15:0], 16'd0};
            default: result_o = 32'd0;
        endcase
    end

    assign zero_o = (result_o == 32'd0);

endmodule

// File: rtl/mips_ctrl_dec.sv
// Instruction decoder: maps op/funct to the control bundle; anything unlisted decodes as nop.
module mips_ctrl_dec
    import mips_pkg::*;
(
    input  logic [31:0] ins_i,
    output ctrl_t       ctrl_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       r_alu;
    alu_op_e    r_op;
    alu_op_e    i_op;

    assign op    = ins_i[31:26];
    assign rt    = ins_i[20:16];
    assign funct = ins_i[5:0];

    always_comb begin
        r_alu = 1'b1;
        r_op  = AluAddu;
        case (funct)
            FnAddu:  r_op = AluAddu;
            FnSubu:  r_op = AluSubu;
            FnAdd:   r_op = AluAdd;
            FnSub:   r_op = AluSub;
            FnAnd:   r_op = AluAnd;
            FnOr:    r_op = AluOr;
            FnXor:   r_op = AluXor;
            FnNor:   r_op = AluNor;
            FnSlt:   r_op = AluSlt;
            FnSltu:  r_op = AluSltu;
            FnSll:   r_op = AluSll;
            FnSrl:   r_op = AluSrl;
            FnSra:   r_op = AluSra;
            FnSllv:  r_op = AluSllv;
            FnSrlv:  r_op = AluSrlv;
            FnSrav:  r_op = AluSrav;
            default: r_alu = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            OpAddi:  i_op = AluAdd;
            OpSlti:  i_op = AluSlt;
            OpSltiu: i_op = AluSltu;
            OpAndi:  i_op = AluAnd;
            OpOri:   i_op = AluOr;
            OpXori:  i_op = AluXor;
            OpLui:   i_op = AluLui;
            default: i_op = AluAddu;
        endcase
    end

    always_comb begin
        ctrl_o = CtrlNop;
        case (op)
            OpRtype: begin
                if (r_alu) begin
                    ctrl_o.reg_dst = 1'b1;
                    ctrl_o.reg_wr  = 1'b1;
                    ctrl_o.alu_op  = r_op;
                end else if (funct == FnJr) begin
                    ctrl_o.jump = 1'b1;
                end else if (funct == FnJalr) begin
                    ctrl_o.jump    = 1'b1;
                    ctrl_o.reg_l   = 1'b1;
                    ctrl_o.reg_wr  = 1'b1;
                    ctrl_o.reg_dst = 1'b1;
                end
            end
            OpRegimm: begin
                // rt=0 bltz, rt=1 bgez; the next-PC logic inspects busA itself.
                if (rt == 5'd0 || rt == 5'd1) begin
                    ctrl_o.branch = BrRegimm;
                    ctrl_o.alu_op = AluSubu;
                end
            end
            OpJ: ctrl_o.jump = 1'b1;
            OpJal: begin
                ctrl_o.jump   = 1'b1;
                ctrl_o.reg_l  = 1'b1;
                ctrl_o.reg_wr = 1'b1;
            end
            OpBeq, OpBne: begin
                ctrl_o.branch = (op == OpBeq) ? BrBeq : BrBne;
                ctrl_o.alu_op = AluSubu;
                ctrl_o.ext_op = 1'b1;
            end
            OpAddi, OpAddiu, OpSlti, OpSltiu, OpAndi, OpOri, OpXori, OpLui: begin
                ctrl_o.reg_wr  = 1'b1;
                ctrl_o.alu_src = 1'b1;
                ctrl_o.ext_op  = !(op == OpAndi || op == OpOri || op == OpXori);
                ctrl_o.alu_op  = i_op;
            end
            OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw: begin
                ctrl_o.alu_src       = 1'b1;
                ctrl_o.ext_op        = 1'b1;
                ctrl_o.reg_wr        = !op[3];
                ctrl_o.mem_to_reg    = !op[3];
                ctrl_o.mem_wr        = op[3];
                // op[1:0] encodes access width, op[2] the unsigned load variants.
                ctrl_o.load_unsigned = op[2];
                case (op[1:0])
                    2'b00:   ctrl_o.mem_size = MemByte;
                    2'b01:   ctrl_o.mem_size = MemHalf;
                    default: ctrl_o.mem_size = MemWord;
                endcase
            end
            default: ctrl_o = CtrlNop;
        endcase
    end

endmodule

// File: rtl/mips_dmem.sv
// Little-endian byte-lane data memory: async read with load extension, write on rising clk,
// asynchronously cleared while reset is low.
module mips_dmem
    import mips_pkg::*;
#(
    parameter int unsigned DmWords = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        we_i,
    input  mem_size_e   size_i,
    input  logic        load_unsigned_i,
    output logic [31:0] rdata_o
);

    localparam int unsigned Aw = $clog2(DmWords);

    logic [31:0]   mem_q [DmWords];
    logic [Aw-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   rd_word;
    logic [15:0]   rd_half;
    logic [7:0]    rd_byte;

    assign idx = addr_i[Aw+1:2];

    always_comb begin
        case (size_i)
            MemWord: begin
                be    = 4'hf;
                wlane = wdata_i;
            end
            MemHalf: begin
                be    = addr_i[1] ? 4'hc : 4'h3;
                wlane = {2{wdata_i[15:0]}};
            end
            MemByte: begin
                be    = 4'b0001 << addr_i[1:0];
                wlane = {4{wdata_i[7:0]}};
            end
            default: begin
                be    = 4'h0;
                wlane = wdata_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DmWords; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wlane[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem_q[idx];
    assign rd_half = addr_i[1] ? rd_word[31:16] : rd_word[15:0];
    assign rd_byte = rd_word[8*addr_i[1:0] +: 8];

    always_comb begin
        case (size_i)
            MemHalf: rdata_o = {{16{rd_half[15] & ~load_unsigned_i}}, rd_half};
            MemByte: rdata_o = {{24{rd_byte[7] & ~load_unsigned_i}}, rd_byte};
            default: rdata_o = rd_word;
        endcase
    end

endmodule

// File: rtl/mips_exec_core.sv
// Single-cycle MIPS execute + memory stage: decode, ALU operand select, data memory and
// write-back mux.
module mips_exec_core
    import mips_pkg::*;
#(
    parameter int unsigned DM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins,
    input  logic [31:0] busA,
    input  logic [31:0] busB,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic [31:0] wb_data,
    output logic [1:0]  branch,
    output logic        jump,
    output logic        regDst,
    output logic        regL,
    output logic        regWr,
    output logic        memWr,
    output logic        extOp,
    output logic        memToReg
);

    ctrl_t       ctrl;
    logic [31:0] imm_ext;
    logic [31:0] alu_b;
    logic [31:0] load_data;

    mips_ctrl_dec u_ctrl_dec (
        .ins_i  (ins),
        .ctrl_o (ctrl)
    );

    assign imm_ext = ctrl.ext_op ? {{16{ins[15]}}, ins[15:0]} : {16'd0, ins[15:0]};
    assign alu_b   = ctrl.alu_src ? imm_ext : busB;

    mips_alu_unit u_alu_unit (
        .alu_op_i (ctrl.alu_op),
        .a_i      (busA),
        .b_i      (alu_b),
        .shamt_i  (ins[10:6]),
        .result_o (alu_out),
        .zero_o   (zero)
    );

    mips_dmem #(
        .DmWords (DM_WORDS)
    ) u_dmem (
        .clk_i           (clk),
        .rst_ni          (rst),
        .addr_i          (alu_out),
        .wdata_i         (busB),
        .we_i            (ctrl.mem_wr),
        .size_i          (ctrl.mem_size),
        .load_unsigned_i (ctrl.load_unsigned),
        .rdata_o         (load_data)
    );

    assign wb_data  = ctrl.mem_to_reg ? load_data : alu_out;
    assign branch   = ctrl.branch;
    assign jump     = ctrl.jump;
    assign regDst   = ctrl.reg_dst;
    assign regL     = ctrl.reg_l;
    assign regWr    = ctrl.reg_wr;
    assign memWr    = ctrl.mem_wr;
    assign extOp    = ctrl.ext_op;
    assign memToReg = ctrl.mem_to_reg;

endmodule

// File: tb/tb_mips_exec_core.sv
// Randomized self-checking bench for mips_exec_core against a byte-array memory model
// and arithmetic reference functions.
module tb_mips_exec_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ins = 32'd0;
    logic [31:0] busA = 32'd0;
    logic [31:0] busB = 32'd0;
    logic [31:0] alu_out;
    logic        zero;
    logic [31:0] wb_data;
    logic [1:0]  branch;
    logic        jump, regDst, regL, regWr, memWr, extOp, memToReg;
    logic [7:0]  cv;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ref_mem [4096];
    logic [5:0]  pend_op;
    logic [11:0] pend_addr;
    logic [31:0] pend_data;

    logic [5:0] r_fns [16] = '{6'h21, 6'h23, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] i_ops [8]  = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f};
    logic [5:0] ld_ops [5] = '{6'h23, 6'h21, 6'h25, 6'h20, 6'h24};
    logic [5:0] st_ops [3] = '{6'h2b, 6'h29, 6'h28};

    mips_exec_core #(.DM_WORDS(1024)) dut (
        .clk      (clk),
        .rst      (rst),
        .ins      (ins),
        .busA     (busA),
        .busB     (busB),
        .alu_out  (alu_out),
        .zero     (zero),
        .wb_data  (wb_data),
        .branch   (branch),
        .jump     (jump),
        .regDst   (regDst),
        .regL     (regL),
        .regWr    (regWr),
        .memWr    (memWr),
        .extOp    (extOp),
        .memToReg (memToReg)
    );

    assign cv = {branch, jump, regDst, regL, regWr, memWr, memToReg};

    always #5 clk = ~clk;

    function automatic logic [31:0] sx(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] ref_r(input logic [5:0] fn, input logic [31:0] a, b,
                                          input logic [4:0] sh);
        case (fn)
            6'h20, 6'h21: return a + b;
            6'h22, 6'h23: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h26: return a ^ b;
            6'h27: return ~(a | b);
            6'h2a: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6'h2b: return (a < b) ? 32'd1 : 32'd0;
            6'h00: return b << sh;
            6'h02: return b >> sh;
            6'h03: return 32'(int'(b) >>> sh);
            6'h04: return b << a[4:0];
            6'h06: return b >> a[4:0];
            6'h07: return 32'(int'(b) >>> a[4:0]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_i(input logic [5:0] op, input logic [31:0] a,
                                          input logic [15:0] imm);
        logic [31:0] se;
        logic [31:0] ze;
        se = sx(imm);
        ze = {16'd0, imm};
        case (op)
            6'h08, 6'h09: return a + se;
            6'h0a: return (int'(a) < int'(se)) ? 32'd1 : 32'd0;
            6'h0b: return (a < se) ? 32'd1 : 32'd0;
            6'h0c: return a & ze;
            6'h0d: return a | ze;
            6'h0e: return a ^ ze;
            6'h0f: return {imm, 16'd0};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [11:0] a);
        logic [11:0] w;
        logic [11:0] h;
        w = a & 12'hffc;
        h = a & 12'hffe;
        case (op)
            6'h23: return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
            6'h21: return sx({ref_mem[h+1], ref_mem[h]});
            6'h25: return {16'd0, ref_mem[h+1], ref_mem[h]};
            6'h20: return {{24{ref_mem[a][7]}}, ref_mem[a]};
            default: return {24'd0, ref_mem[a]};
        endcase
    endfunction

    function automatic bit valid_op(input logic [5:0] op);
        return op inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b,
                          6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                          6'h28, 6'h29, 6'h2b};
    endfunction

    task automatic drive(input logic [31:0] i, a, b);
        @(negedge clk);
        ins  = i;
        busA = a;
        busB = b;
        #1;
    endtask

    // Address target: the low 12 bits of busA + sext(imm) land on tgt, high bits random.
    task automatic load_drive(input logic [5:0] op, input logic [11:0] tgt);
        logic [15:0] imm;
        logic [31:0] hi;
        imm = 16'($urandom);
        hi  = $urandom & 32'hffff_f000;
        drive(i_ins(op, 5'($urandom), 5'($urandom), imm), (hi | {20'd0, tgt}) - sx(imm),
              $urandom);
    endtask

    task automatic store_begin(input logic [5:0] op, input logic [11:0] tgt,
                               input logic [31:0] data);
        logic [15:0] imm;
        logic [31:0] hi;
        imm = 16'($urandom);
        hi  = $urandom & 32'hffff_f000;
        pend_op   = op;
        pend_addr = tgt;
        pend_data = data;
        drive(i_ins(op, 5'($urandom), 5'($urandom), imm), (hi | {20'd0, tgt}) - sx(imm), data);
    endtask

    task automatic store_end();
        logic [11:0] w;
        logic [11:0] h;
        @(posedge clk);
        if (rst) begin
            w = pend_addr & 12'hffc;
            h = pend_addr & 12'hffe;
            case (pend_op)
                6'h2b: for (int k = 0; k < 4; k++) ref_mem[w + 12'(k)] = pend_data[8*k +: 8];
                6'h29: begin
                    ref_mem[h]   = pend_data[7:0];
                    ref_mem[h+1] = pend_data[15:8];
                end
                default: ref_mem[pend_addr] = pend_data[7:0];
            endcase
        end
        #1;
        ins = 32'd0;
    endtask

    task automatic test_reset();
        logic [11:0] t;
        for (int i = 0; i < 4; i++) begin
            t = 12'($urandom);
            load_drive(6'h23, t);
            checks++;
            if (wb_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_load addr=%h got=%h want=00000000", t, wb_data);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        drive(r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd7, 32'hffff_fff9);
        checks++;
        if (alu_out !== 32'd0 || zero !== 1'b1 || regDst !== 1'b1 || regWr !== 1'b1) begin
            errors++;
            $display("FAIL addu_zero alu=%h zero=%b regDst=%b regWr=%b want 0/1/1/1",
                     alu_out, zero, regDst, regWr);
        end
        drive(i_ins(6'h0d, 5'd1, 5'd2, 16'h8000), 32'h0001_0000, 32'hdead_beef);
        checks++;
        if (alu_out !== 32'h0001_8000 || extOp !== 1'b0) begin
            errors++;
            $display("FAIL ori_zext alu=%h extOp=%b want 00018000/0", alu_out, extOp);
        end
        drive(i_ins(6'h09, 5'd1, 5'd2, 16'h8000), 32'd0, 32'd0);
        checks++;
        if (alu_out !== 32'hffff_8000 || extOp !== 1'b1) begin
            errors++;
            $display("FAIL addiu_sext alu=%h extOp=%b want ffff8000/1", alu_out, extOp);
        end
        drive(r_ins(5'd0, 5'd2, 5'd3, 5'd4, 6'h03), 32'd0, 32'h8000_0000);
        checks++;
        if (alu_out !== 32'hf800_0000) begin
            errors++;
            $display("FAIL sra4 got=%h want=f8000000", alu_out);
        end
        drive(r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h2a), 32'hffff_ffff, 32'd1);
        checks++;
        if (alu_out !== 32'd1) begin
            errors++;
            $display("FAIL slt_neg got=%h want=00000001", alu_out);
        end
        drive(r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h2b), 32'hffff_ffff, 32'd1);
        checks++;
        if (alu_out !== 32'd0) begin
            errors++;
            $display("FAIL sltu_neg got=%h want=00000000", alu_out);
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [31:0] a, b, exp;
        for (int i = 0; i < 48; i++) begin
            fn = r_fns[$urandom_range(0, 15)];
            sh = 5'($urandom);
            a  = $urandom;
            b  = (i % 4 == 0) ? a : $urandom;
            exp = ref_r(fn, a, b, sh);
            drive(r_ins(5'($urandom), 5'($urandom), 5'($urandom), sh, fn), a, b);
            checks++;
            if (alu_out !== exp || wb_data !== exp || zero !== (exp == 32'd0)
                || cv !== 8'b00_0_1_0_1_0_0) begin
                errors++;
                $display("FAIL rtype fn=%h a=%h b=%h sh=%0d got=%h/%h z=%b cv=%b want=%h",
                         fn, a, b, sh, alu_out, wb_data, zero, cv, exp);
            end
        end
    endtask

    task automatic test_itype();
        logic [5:0]  op;
        logic [15:0] imm;
        logic [31:0] a, exp;
        logic        ext;
        for (int i = 0; i < 48; i++) begin
            op  = i_ops[$urandom_range(0, 7)];
            imm = 16'($urandom);
            a   = $urandom;
            exp = ref_i(op, a, imm);
            ext = !(op inside {6'h0c, 6'h0d, 6'h0e});
            drive(i_ins(op, 5'($urandom), 5'($urandom), imm), a, $urandom);
            checks++;
            if (alu_out !== exp || wb_data !== exp || extOp !== ext
                || cv !== 8'b00_0_0_0_1_0_0) begin
                errors++;
                $display("FAIL itype op=%h a=%h imm=%h got=%h extOp=%b cv=%b want=%h ext=%b",
                         op, a, imm, alu_out, extOp, cv, exp, ext);
            end
        end
    endtask

    task automatic test_branch_jump();
        logic [31:0] a, b;
        drive(32'h0721_0010, $urandom, $urandom);
        checks++;
        if (branch !== 2'b11 || regWr !== 1'b0 || memWr !== 1'b0 || jump !== 1'b0) begin
            errors++;
            $display("FAIL bgez branch=%b regWr=%b memWr=%b jump=%b want 11/0/0/0",
                     branch, regWr, memWr, jump);
        end
        drive(i_ins(6'h04, 5'd1, 5'd2, 16'h0004), 32'd5, 32'd5);
        checks++;
        if (branch !== 2'b01 || zero !== 1'b1 || regWr !== 1'b0) begin
            errors++;
            $display("FAIL beq_eq branch=%b zero=%b regWr=%b want 01/1/0", branch, zero, regWr);
        end
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = (i % 2 == 0) ? a : $urandom;
            drive(i_ins((i % 4 < 2) ? 6'h04 : 6'h05, 5'd3, 5'd4, 16'($urandom)), a, b);
            checks++;
            if (branch !== ((i % 4 < 2) ? 2'b01 : 2'b10) || zero !== (a == b)
                || alu_out !== a - b || {jump, regWr, memWr} !== 3'b000) begin
                errors++;
                $display("FAIL beq_bne i=%0d a=%h b=%h branch=%b zero=%b alu=%h", i, a, b,
                         branch, zero, alu_out);
            end
        end
        drive({6'h02, 26'($urandom)}, $urandom, $urandom);
        checks++;
        if ({branch, jump, regL, regWr, memWr} !== 6'b00_1_0_0_0) begin
            errors++;
            $display("FAIL j got=%b want=001000", {branch, jump, regL, regWr, memWr});
        end
        drive({6'h03, 26'($urandom)}, $urandom, $urandom);
        checks++;
        if ({branch, jump, regL, regWr, memWr} !== 6'b00_1_1_1_0) begin
            errors++;
            $display("FAIL jal got=%b want=001110", {branch, jump, regL, regWr, memWr});
        end
        drive(r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), $urandom, $urandom);
        checks++;
        if (cv !== 8'b00_1_0_0_0_0_0) begin
            errors++;
            $display("FAIL jr cv=%b want=00100000", cv);
        end
        drive(r_ins(5'd5, 5'd0, 5'd7, 5'd0, 6'h09), $urandom, $urandom);
        checks++;
        if (cv !== 8'b00_1_1_1_1_0_0) begin
            errors++;
            $display("FAIL jalr cv=%b want=00111100", cv);
        end
    endtask

    task automatic test_nop();
        logic [5:0] op;
        logic [5:0] fn;
        for (int i = 0; i < 40; i++) begin
            op = 6'($urandom);
            if (valid_op(op)) continue;
            drive({op, 26'($urandom)}, $urandom, $urandom);
            checks++;
            if ({branch, jump, regL, regWr, memWr} !== 6'd0) begin
                errors++;
                $display("FAIL nop_op op=%h got=%b want=000000", op,
                         {branch, jump, regL, regWr, memWr});
            end
        end
        for (int i = 0; i < 24; i++) begin
            fn = 6'($urandom);
            if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09}
                || fn inside {[6'h20:6'h27], 6'h2a, 6'h2b}) continue;
            drive(r_ins(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fn),
                  $urandom, $urandom);
            checks++;
            if ({branch, jump, regL, regWr, memWr} !== 6'd0) begin
                errors++;
                $display("FAIL nop_funct fn=%h got=%b want=000000", fn,
                         {branch, jump, regL, regWr, memWr});
            end
        end
    endtask

    task automatic test_mem();
        logic [5:0]  op;
        logic [11:0] t;
        logic [31:0] exp;
        store_begin(6'h2b, 12'h010, 32'h1122_3344);
        store_end();
        load_drive(6'h20, 12'h013);
        checks++;
        if (wb_data !== 32'h0000_0011) begin
            errors++;
            $display("FAIL lb_13 got=%h want=00000011", wb_data);
        end
        store_begin(6'h28, 12'h011, 32'h0000_0080);
        store_end();
        load_drive(6'h20, 12'h011);
        checks++;
        if (wb_data !== 32'hffff_ff80) begin
            errors++;
            $display("FAIL lb_11 got=%h want=ffffff80", wb_data);
        end
        load_drive(6'h24, 12'h011);
        checks++;
        if (wb_data !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu_11 got=%h want=00000080", wb_data);
        end
        for (int i = 0; i < 40; i++) begin
            op = st_ops[$urandom_range(0, 2)];
            t  = 12'h100 + 12'($urandom_range(0, 31));
            store_begin(op, t, $urandom);
            checks++;
            if (memWr !== 1'b1 || regWr !== 1'b0 || extOp !== 1'b1) begin
                errors++;
                $display("FAIL store_ctrl op=%h memWr=%b regWr=%b extOp=%b want 1/0/1",
                         op, memWr, regWr, extOp);
            end
            store_end();
            op  = ld_ops[$urandom_range(0, 4)];
            t   = 12'h100 + 12'($urandom_range(0, 31));
            exp = ref_load(op, t);
            load_drive(op, t);
            checks++;
            if (wb_data !== exp || alu_out[11:0] !== t || cv !== 8'b00_0_0_0_1_0_1) begin
                errors++;
                $display("FAIL load op=%h addr=%h got=%h cv=%b want=%h", op, t, wb_data, cv,
                         exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        d = $urandom | 32'h1;
        store_begin(6'h2b, 12'h040, d);
        store_end();
        load_drive(6'h23, 12'h040);
        checks++;
        if (wb_data !== d) begin
            errors++;
            $display("FAIL pre_reset got=%h want=%h", wb_data, d);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (wb_data !== 32'd0) begin
            errors++;
            $display("FAIL async_clear got=%h want=00000000", wb_data);
        end
        for (int k = 0; k < 4096; k++) ref_mem[k] = 8'd0;
        store_begin(6'h2b, 12'h044, $urandom | 32'h1);
        store_end();
        @(negedge clk);
        rst = 1'b1;
        load_drive(6'h23, 12'h044);
        checks++;
        if (wb_data !== 32'd0) begin
            errors++;
            $display("FAIL store_in_reset got=%h want=00000000", wb_data);
        end
        for (int i = 0; i < 4; i++) begin
            load_drive(6'h23, 12'h100 + 12'(4 * i));
            checks++;
            if (wb_data !== 32'd0) begin
                errors++;
                $display("FAIL cleared_word i=%0d got=%h want=00000000", i, wb_data);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) ref_mem[k] = 8'd0;
        #1;
        rst = 1'b0;
        test_reset();
        test_directed();
        test_rtype();
        test_itype();
        test_branch_jump();
        test_nop();
        test_mem();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
